// File: rtl/joypad_port.sv
// Controller-port responder emulating two 4021-style NES pads behind the CPU's
// $4016/$4017 read enables and the $4016 OUT latch.
module joypad_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] addr4016w,
    input  logic       naddr4016r,
    input  logic       naddr4017r,
    input  logic [7:0] buttons1,
    input  logic [7:0] buttons2,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [1:0] expansion_out
);

    logic [7:0] sync1 [SYNC_STAGES];
    logic [7:0] sync2 [SYNC_STAGES];
    logic [7:0] btn_s1;
    logic [7:0] btn_s2;
    logic [7:0] sr1;
    logic [7:0] sr2;
    logic       nread1_q;
    logic       nread2_q;
    logic       strobe;
    logic       shift1;
    logic       shift2;

    assign btn_s1 = sync1[SYNC_STAGES-1];
    assign btn_s2 = sync2[SYNC_STAGES-1];
    assign strobe = addr4016w[0];

    // A port advances on the rising edge of its enable, i.e. when the read ends.
    assign shift1 = !nread1_q && naddr4016r;
    assign shift2 = !nread2_q && naddr4017r;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync1[i] <= '0;
                sync2[i] <= '0;
            end
        end else begin
            sync1[0] <= buttons1;
            sync2[0] <= buttons2;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync1[i] <= sync1[i-1];
                sync2[i] <= sync2[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr1           <= 8'hFF;
            sr2           <= 8'hFF;
            nread1_q      <= 1'b1;
            nread2_q      <= 1'b1;
            expansion_out <= 2'b00;
        end else begin
            nread1_q      <= naddr4016r;
            nread2_q      <= naddr4017r;
            expansion_out <= addr4016w[2:1];

            if (strobe) begin
                sr1 <= btn_s1;
            end else if (shift1) begin
                sr1 <= {1'b1, sr1[7:1]};
            end

            if (strobe) begin
                sr2 <= btn_s2;
            end else if (shift2) begin
                sr2 <= {1'b1, sr2[7:1]};
            end
        end
    end

    // Bits [7:5] mimic the open-bus value $40 left on the CPU data bus.
    always_comb begin
        data_out = 8'h00;
        if (!naddr4016r) begin
            data_out = {3'b010, 4'b0000, sr1[0]};
        end else if (!naddr4017r) begin
            data_out = {3'b010, 4'b0000, sr2[0]};
        end
    end

    assign data_valid = !naddr4016r || !naddr4017r;

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port: directed scenarios plus random traffic, all checked
// against a pad model that tracks "latched byte + number of completed reads".
module tb_joypad_port;
    localparam int S = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] addr4016w;
    logic       naddr4016r;
    logic       naddr4017r;
    logic [7:0] buttons1;
    logic [7:0] buttons2;
    logic [7:0] data_out;
    logic       data_valid;
    logic [1:0] expansion_out;

    joypad_port #(.SYNC_STAGES(S)) dut (
        .clock(clock),
        .reset(reset),
        .addr4016w(addr4016w),
        .naddr4016r(naddr4016r),
        .naddr4017r(naddr4017r),
        .buttons1(buttons1),
        .buttons2(buttons2),
        .data_out(data_out),
        .data_valid(data_valid),
        .expansion_out(expansion_out)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each pad is the byte captured at its last strobe and a count of
    // reads completed since then; read k returns bit k, or 1 once k >= 8.
    logic [7:0] m_lat1, m_lat2;
    int         m_k1, m_k2;
    logic       m_prev_low1, m_prev_low2;
    logic [1:0] m_exp;
    logic [7:0] hist1 [$];
    logic [7:0] hist2 [$];
    logic [7:0] last_do;

    function automatic logic pad_bit(logic [7:0] lat, int k);
        logic [7:0] v;
        v = lat;
        return (k >= 8) ? 1'b1 : v[k];
    endfunction

    task automatic check_val(string tag, logic [7:0] got, logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_hist();
        hist1.delete();
        hist2.delete();
        for (int i = 0; i < S; i++) begin
            hist1.push_back(8'h00);
            hist2.push_back(8'h00);
        end
    endtask

    task automatic model_edge();
        logic [7:0] d1, d2;
        logic       end1, end2;
        d1 = hist1[S-1];
        d2 = hist2[S-1];
        if (reset) begin
            m_lat1 = 8'hFF; m_lat2 = 8'hFF;
            m_k1 = 0; m_k2 = 0;
            m_prev_low1 = 1'b0; m_prev_low2 = 1'b0;
            m_exp = 2'b00;
            clear_hist();
        end else begin
            end1 = m_prev_low1 && naddr4016r;
            end2 = m_prev_low2 && naddr4017r;
            if (addr4016w[0]) begin
                m_lat1 = d1; m_k1 = 0;
                m_lat2 = d2; m_k2 = 0;
            end else begin
                if (end1 && m_k1 < 8) m_k1++;
                if (end2 && m_k2 < 8) m_k2++;
            end
            hist1.push_front(buttons1); void'(hist1.pop_back());
            hist2.push_front(buttons2); void'(hist2.pop_back());
            m_prev_low1 = !naddr4016r;
            m_prev_low2 = !naddr4017r;
            m_exp = addr4016w[2:1];
        end
    endtask

    // Called just after a clock edge with inputs already driven: checks the
    // outputs for the current cycle, then advances DUT and model one edge.
    task automatic step();
        logic [7:0] e;
        #2;
        e = 8'h00;
        if (!naddr4016r)      e = {7'b0100000, pad_bit(m_lat1, m_k1)};
        else if (!naddr4017r) e = {7'b0100000, pad_bit(m_lat2, m_k2)};
        check_val("data_out", data_out, e);
        check_val("data_valid", {7'b0, data_valid}, {7'b0, !naddr4016r || !naddr4017r});
        check_val("expansion_out", {6'b0, expansion_out}, {6'b0, m_exp});
        last_do = data_out;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic read1(output logic d0);
        naddr4016r = 1'b0; step(); d0 = last_do[0];
        naddr4016r = 1'b1; step();
    endtask

    task automatic read2(output logic d0);
        naddr4017r = 1'b0; step(); d0 = last_do[0];
        naddr4017r = 1'b1; step();
    endtask

    task automatic latch();
        addr4016w[0] = 1'b1;
        for (int i = 0; i < S + 3; i++) step();
        addr4016w[0] = 1'b0;
        step();
    endtask

    initial begin
        logic       d0;
        logic [9:0] exp_seq;

        reset = 1'b1; addr4016w = 3'b000; naddr4016r = 1'b1; naddr4017r = 1'b1;
        buttons1 = 8'h00; buttons2 = 8'h00;
        clear_hist();
        @(posedge clock); model_edge(); #1;
        step();
        reset = 1'b0;
        step();

        // Reads before any strobe return 1.
        for (int i = 0; i < 3; i++) begin
            read1(d0);
            check_val("pre_strobe_d0", {7'b0, d0}, 8'h01);
        end

        // Pattern 1010_0101 shifted out LSB first, then ones.
        buttons1 = 8'b1010_0101;
        latch();
        exp_seq = 10'b11_1010_0101;
        for (int i = 0; i < 10; i++) begin
            read1(d0);
            check_val($sformatf("pattern_read%0d", i), {7'b0, d0}, {7'b0, exp_seq[i]});
        end

        // Strobe held: reads never advance; button change lands after S+1 edges.
        buttons1 = 8'h01;
        addr4016w[0] = 1'b1;
        for (int i = 0; i < S + 2; i++) step();
        for (int i = 0; i < 5; i++) begin
            read1(d0);
            check_val("strobe_hold_d0", {7'b0, d0}, 8'h01);
        end
        buttons1 = 8'h00;
        naddr4016r = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            step();
            check_val($sformatf("latency_edge%0d", i), last_do, (i < S + 1) ? 8'h41 : 8'h40);
        end
        naddr4016r = 1'b1;
        addr4016w[0] = 1'b0;
        step();

        // A read held low several cycles shifts only once.
        buttons1 = 8'h02;
        latch();
        naddr4016r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("held_read_d0", last_do, 8'h40);
        end
        naddr4016r = 1'b1;
        step();
        read1(d0);
        check_val("after_held_d0", {7'b0, d0}, 8'h01);

        // Ports advance independently.
        buttons1 = 8'h00; buttons2 = 8'h80;
        latch();
        for (int i = 0; i < 8; i++) begin
            read2(d0);
            check_val($sformatf("port2_read%0d", i), {7'b0, d0}, (i == 7) ? 8'h01 : 8'h00);
        end
        read1(d0);
        check_val("port1_indep", {7'b0, d0}, 8'h00);

        // Strobe falling in the cycle a read ends still shifts.
        buttons1 = 8'h02;
        latch();
        addr4016w[0] = 1'b1;
        naddr4016r = 1'b0; step();
        naddr4016r = 1'b1; addr4016w[0] = 1'b0; step();
        read1(d0);
        check_val("strobe_fall_shift", {7'b0, d0}, 8'h01);

        // Reset in the middle of a read: no shift when the enable rises.
        buttons1 = 8'h00;
        latch();
        read1(d0); read1(d0);
        naddr4016r = 1'b0; step();
        reset = 1'b1; step();
        reset = 1'b0; naddr4016r = 1'b1; step();
        read1(d0);
        check_val("post_reset_d0", {7'b0, d0}, 8'h01);
        check_val("post_reset_exp", {6'b0, expansion_out}, 8'h00);
        addr4016w = 3'b110;
        step();
        check_val("exp_one_cycle", {6'b0, expansion_out}, 8'h03);
        addr4016w = 3'b000;
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) buttons1 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) buttons2 = 8'($urandom);
            addr4016w  = {2'($urandom), ($urandom_range(0, 19) == 0)};
            naddr4016r = ($urandom_range(0, 9) >= 4);
            naddr4017r = ($urandom_range(0, 9) >= 4);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
